// File: rtl/dwconv_add_ctrl_pkg.sv
// Shared types and default sizes for the depthwise-conv bias-add sequencers.
// The tag widths must stay in step with the add stage's 5-bit cnt and 4-bit pos inputs.
package dwconv_add_ctrl_pkg;

  localparam int DW_CH_NUM  = 32;
  localparam int DW_POS_NUM = 9;
  localparam int DW_CNT_W   = 5;
  localparam int DW_POS_W   = 4;
  localparam int DW_BIAS_W  = 32;
  localparam int DW_LAT_W   = 2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_BIAS_REQ  = 3'd1,
    S_BIAS_WAIT = 3'd2,
    S_RUN       = 3'd3,
    S_DONE      = 3'd4
  } dw_state_t;

endpackage

// File: rtl/dwconv_pos_ch_counter.sv
// Nested position/channel counter: pos wraps every POS_NUM beats and carries into ch.
// ch saturates at CH_NUM-1 so the last channel never wraps inside a pass.
module dwconv_pos_ch_counter #(
  parameter int CH_NUM  = 32,
  parameter int POS_NUM = 9,
  parameter int CNT_W   = 5,
  parameter int POS_W   = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] ch,
  output logic [POS_W-1:0] pos,
  output logic             pos_last,
  output logic             ch_last
);

  assign pos_last = (pos == POS_W'(POS_NUM - 1));
  assign ch_last  = (ch == CNT_W'(CH_NUM - 1));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ch  <= '0;
      pos <= '0;
    end else if (clr) begin
      ch  <= '0;
      pos <= '0;
    end else if (inc) begin
      if (pos_last) begin
        pos <= '0;
        if (!ch_last) ch <= ch + CNT_W'(1);
      end else begin
        pos <= pos + POS_W'(1);
      end
    end
  end

endmodule

// File: rtl/dwconv_add_ctrl.sv
// Bias-add stage sequencer: fetches one bias per channel, then issues POS_NUM
// beats gated by upstream valid and downstream ready.
//
// state     | meaning
// S_IDLE    | waiting for start
// S_BIAS_REQ| bias_rd_en high for one cycle, address = current channel
// S_BIAS_WAIT| counting down the bias memory latency, capture on exit
// S_RUN     | issuing beats for the current channel
// S_DONE    | one-cycle done pulse, then back to idle
module dwconv_add_ctrl
  import dwconv_add_ctrl_pkg::*;
#(
  parameter int CH_NUM   = DW_CH_NUM,
  parameter int POS_NUM  = DW_POS_NUM,
  parameter int CNT_W    = DW_CNT_W,
  parameter int POS_W    = DW_POS_W,
  parameter int BIAS_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic                 down_ready,
  output logic                 bias_rd_en,
  output logic [CNT_W-1:0]     bias_rd_addr,
  input  logic [DW_BIAS_W-1:0] bias_rd_data,
  output logic [DW_BIAS_W-1:0] bias_out,
  output logic                 add_en,
  output logic [CNT_W-1:0]     cnt_in_o,
  output logic [POS_W-1:0]     pos_in_o,
  output logic                 out_valid
);

  dw_state_t           state;
  logic [DW_LAT_W-1:0] lat_cnt;
  logic [CNT_W-1:0]    ch;
  logic [POS_W-1:0]    pos;
  logic                pos_last;
  logic                ch_last;
  logic                cnt_clr;

  assign add_en       = (state == S_RUN) && up_valid && down_ready;
  assign up_ready     = add_en;
  assign cnt_in_o     = ch;
  assign pos_in_o     = pos;
  assign bias_rd_addr = ch;
  assign cnt_clr      = (state == S_IDLE) && start;

  dwconv_pos_ch_counter #(
    .CH_NUM (CH_NUM),
    .POS_NUM(POS_NUM),
    .CNT_W  (CNT_W),
    .POS_W  (POS_W)
  ) u_cnt (
    .clk     (clk),
    .rst_b   (rst_b),
    .clr     (cnt_clr),
    .inc     (add_en),
    .ch      (ch),
    .pos     (pos),
    .pos_last(pos_last),
    .ch_last (ch_last)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      bias_rd_en <= 1'b0;
      bias_out   <= '0;
      lat_cnt    <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid  <= add_en;
      done       <= 1'b0;
      bias_rd_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_BIAS_REQ;
            busy       <= 1'b1;
            bias_rd_en <= 1'b1;
          end
        end
        S_BIAS_REQ: begin
          state   <= S_BIAS_WAIT;
          lat_cnt <= DW_LAT_W'(BIAS_LAT);
        end
        S_BIAS_WAIT: begin
          lat_cnt <= lat_cnt - DW_LAT_W'(1);
          // Counter hits zero on this edge: read data is valid now.
          if (lat_cnt == DW_LAT_W'(1)) begin
            bias_out <= bias_rd_data;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (add_en && pos_last) begin
            if (ch_last) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state      <= S_BIAS_REQ;
              bias_rd_en <= 1'b1;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
